// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Issues the current PC to instruction memory with at most one request
// outstanding, drives the PC's increment/load controls, and queues returned
// instructions together with their address for the decode stage.
// A taken branch reloads the PC and discards buffered and in-flight words.
module instr_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    output logic                  pc_inc,
    output logic                  pc_jmp,
    output logic [ADDR_WIDTH-1:0] pc_jaddr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [DATA_WIDTH-1:0] ir_data,
    output logic [ADDR_WIDTH-1:0] ir_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    // IDLE: nothing outstanding; WAIT: one outstanding, keep it;
    // DRAIN: one outstanding that a redirect made stale, discard it.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pending_addr;

    logic [CNT_W:0]        occupancy;
    logic                  credit;
    logic                  req_fire;
    logic                  push;
    logic                  pop;

    // Slots already used or promised to the outstanding request. In WAIT with
    // a response arriving, the outstanding slot turns into a filled slot, so
    // the same sum also decides whether a back-to-back request fits.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, (state != IDLE)};
    assign credit    = occupancy < DEPTH_EXT;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign pc_inc    = req_fire;
    assign pc_jmp    = redirect_valid & rst_n;
    assign pc_jaddr  = redirect_addr;
    assign imem_addr = pc_addr;

    assign ir_valid  = rst_n & (count != '0);
    assign pop       = ir_valid & ir_ready;
    assign ir_data   = data_mem[rd_ptr];
    assign ir_pc     = addr_mem[rd_ptr];

    // State register; an outstanding request is simply forgotten on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending_addr <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                pending_addr <= pc_addr;
            end
        end
    end

    // Next-state logic for the single outstanding request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rsp_valid ? IDLE : DRAIN;
                end else if (imem_rsp_valid) begin
                    state_next = req_fire ? WAIT : IDLE;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request and push decode; a redirect cycle never requests so that the
    // next request uses the reloaded PC.
    always_comb begin
        imem_req_valid = 1'b0;
        push           = 1'b0;
        if (rst_n && !redirect_valid) begin
            case (state)
                IDLE: imem_req_valid = credit;
                WAIT: begin
                    if (imem_rsp_valid) begin
                        push           = 1'b1;
                        imem_req_valid = credit;
                    end
                end
                default: imem_req_valid = 1'b0;
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: instruction word paired with the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            addr_mem[wr_ptr] <= pending_addr;
        end
    end

    // Credit must make a push into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            assert (count != DEPTH_EXT[CNT_W-1:0]);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a PC register model and a
// fixed-latency instruction memory model.
module tb_instr_fetch;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc_addr = '0;
    logic          pc_inc;
    logic          pc_jmp;
    logic [AW-1:0] pc_jaddr;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [DW-1:0] imem_rsp_data = '0;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic [DW-1:0] ir_data;
    logic [AW-1:0] ir_pc;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } pop_t;

    pop_t          pop_q[$];
    logic [AW-1:0] req_q[$];
    int            inc_cnt = 0;
    int            both_cnt = 0;
    int            lat = 1;
    int            tests_run = 0;
    int            tests_failed = 0;

    logic          mem_busy = 1'b0;
    int            mem_cd = 0;
    logic [AW-1:0] mem_a = '0;

    instr_fetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr       (pc_addr),
        .pc_inc        (pc_inc),
        .pc_jmp        (pc_jmp),
        .pc_jaddr      (pc_jaddr),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .ir_data       (ir_data),
        .ir_pc         (ir_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    // PC register driven by the fetch stage's inc/jmp controls.
    always @(posedge clk) begin
        if (!rst_n) begin
            pc_addr <= '0;
        end else if (pc_jmp) begin
            pc_addr <= pc_jaddr;
        end else if (pc_inc) begin
            pc_addr <= pc_addr + 1'b1;
        end
    end

    // Instruction memory: answers lat cycles after the request cycle and is
    // deliberately not reset, so stale responses can outlive a fetch reset.
    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (mem_busy) begin
            if (mem_cd <= 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memWord(mem_a);
                mem_busy       <= 1'b0;
            end else begin
                mem_cd <= mem_cd - 1;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            if (lat <= 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memWord(imem_addr);
            end else begin
                mem_busy <= 1'b1;
                mem_cd   <= lat - 1;
                mem_a    <= imem_addr;
            end
        end
    end

    // Log handshakes and decode pops mid-cycle, when all inputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pc_inc) inc_cnt++;
            if (pc_inc && pc_jmp) both_cnt++;
            if (imem_req_valid && imem_req_ready) req_q.push_back(imem_addr);
            if (ir_valid && ir_ready) pop_q.push_back({ir_pc, ir_data});
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic clearLogs();
        pop_q.delete();
        req_q.delete();
        inc_cnt = 0;
    endtask

    task automatic applyStimulus(input logic ready, input logic dec_ready, input int latency);
        imem_req_ready = ready;
        ir_ready       = dec_ready;
        lat            = latency;
    endtask

    task automatic doReset(input logic ready, input logic dec_ready, input int latency);
        nextCycle();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        applyStimulus(ready, dec_ready, latency);
        repeat (4) nextCycle();
        rst_n = 1'b1;
        clearLogs();
    endtask

    task automatic waitPops(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && pop_q.size() < n; i++) probe();
        checkOutput(tag, 32'(pop_q.size() >= n), 32'd1);
    endtask

    task automatic waitReqs(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && req_q.size() < n; i++) probe();
        checkOutput(tag, 32'(req_q.size() >= n), 32'd1);
    endtask

    task automatic checkPops(input int n, input logic [AW-1:0] base, input string tag);
        for (int i = 0; i < n; i++) begin
            if (i < pop_q.size()) begin
                checkOutput($sformatf("%s_pc%0d", tag, i), 32'(pop_q[i].pc), 32'(base + AW'(i)));
                checkOutput($sformatf("%s_data%0d", tag, i), 32'(pop_q[i].data), 32'(memWord(base + AW'(i))));
            end
        end
    endtask

    initial begin
        // Test 1: reset outputs, then in-order streaming from PC 0.
        applyStimulus(1'b1, 1'b1, 1);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h33;
        repeat (2) nextCycle();
        probe();
        checkOutput("t1_rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("t1_rst_pc_inc", 32'(pc_inc), 32'd0);
        checkOutput("t1_rst_pc_jmp", 32'(pc_jmp), 32'd0);
        checkOutput("t1_rst_ir_valid", 32'(ir_valid), 32'd0);
        nextCycle();
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        clearLogs();
        waitPops(4, 60, "t1_pop_count");
        checkPops(4, 8'h00, "t1");
        for (int i = 0; i < 4; i++) begin
            if (i < req_q.size()) checkOutput($sformatf("t1_req%0d", i), 32'(req_q[i]), i);
        end
        checkOutput("t1_inc_per_req", inc_cnt, req_q.size());

        // Test 2: decode stalled, only two requests fit; then resume cleanly.
        doReset(1'b1, 1'b0, 1);
        repeat (12) probe();
        checkOutput("t2_req_count", req_q.size(), 32'd2);
        checkOutput("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
        checkOutput("t2_ir_valid", 32'(ir_valid), 32'd1);
        checkOutput("t2_head_pc", 32'(ir_pc), 32'h0);
        checkOutput("t2_head_data", 32'(ir_data), 32'(memWord(8'h00)));
        checkOutput("t2_pc_value", 32'(pc_addr), 32'h2);
        nextCycle();
        ir_ready = 1'b1;
        waitPops(6, 80, "t2_pop_count");
        checkPops(6, 8'h00, "t2");

        // Test 3: redirect while a slow request is outstanding.
        doReset(1'b1, 1'b1, 3);
        waitReqs(1, 20, "t3_first_req");
        nextCycle();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h40;
        probe();
        checkOutput("t3_pc_jmp", 32'(pc_jmp), 32'd1);
        checkOutput("t3_pc_jaddr", 32'(pc_jaddr), 32'h40);
        checkOutput("t3_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        checkOutput("t3_no_inc_on_redirect", 32'(pc_inc), 32'd0);
        nextCycle();
        redirect_valid = 1'b0;
        probe();
        checkOutput("t3_drain_no_req", 32'(imem_req_valid), 32'd0);
        waitPops(1, 40, "t3_pop_count");
        checkPops(1, 8'h40, "t3");
        if (req_q.size() > 1) checkOutput("t3_second_req", 32'(req_q[1]), 32'h40);

        // Test 4: redirect together with a response and a pop, no credit left.
        doReset(1'b1, 1'b0, 1);
        waitReqs(2, 20, "t4_two_reqs");
        nextCycle();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h80;
        ir_ready       = 1'b1;
        probe();
        checkOutput("t4_rsp_present", 32'(imem_rsp_valid), 32'd1);
        checkOutput("t4_ir_valid_before", 32'(ir_valid), 32'd1);
        checkOutput("t4_pc_inc", 32'(pc_inc), 32'd0);
        checkOutput("t4_pc_jmp", 32'(pc_jmp), 32'd1);
        nextCycle();
        redirect_valid = 1'b0;
        pop_q.delete();
        probe();
        checkOutput("t4_flushed", 32'(ir_valid), 32'd0);
        checkOutput("t4_pc_loaded", 32'(pc_addr), 32'h80);
        waitPops(1, 30, "t4_pop_count");
        checkPops(1, 8'h80, "t4");

        // Test 5: memory not ready for four cycles.
        doReset(1'b0, 1'b1, 1);
        repeat (4) probe();
        checkOutput("t5_req_pending", 32'(imem_req_valid), 32'd1);
        checkOutput("t5_no_inc", inc_cnt, 32'd0);
        checkOutput("t5_pc_stable", 32'(pc_addr), 32'h0);
        nextCycle();
        imem_req_ready = 1'b1;
        waitPops(3, 40, "t5_pop_count");
        checkPops(3, 8'h00, "t5");
        for (int i = 0; i < 3; i++) begin
            if (i < req_q.size()) checkOutput($sformatf("t5_req%0d", i), 32'(req_q[i]), i);
        end

        // Test 6: one-cycle reset in WAIT with a buffered word; stale rsp ignored.
        doReset(1'b1, 1'b0, 3);
        waitReqs(2, 30, "t6_two_reqs");
        nextCycle();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        probe();
        checkOutput("t6_rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        clearLogs();
        probe();
        checkOutput("t6_after_rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("t6_after_rst_pc", 32'(pc_addr), 32'h0);
        repeat (2) nextCycle();
        probe();
        checkOutput("t6_stale_ignored", 32'(ir_valid), 32'd0);
        nextCycle();
        imem_req_ready = 1'b1;
        ir_ready       = 1'b1;
        waitPops(2, 40, "t6_pop_count");
        checkPops(2, 8'h00, "t6");

        checkOutput("never_inc_and_jmp", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
